// File: rtl/mmio_pkg.sv
// Shared types for the memory-mapped port bank: register classes, page size
// and the input-settle state machine encoding.
package mmio_pkg;

    localparam int MMIO_PAGE_BITS = 8;

    typedef enum logic [3:0] {
        CLS_DATA = 4'd0,
        CLS_SET  = 4'd1,
        CLS_CLR  = 4'd2,
        CLS_TGL  = 4'd3,
        CLS_CHG  = 4'd4,
        CLS_ORB  = 4'd5,
        CLS_MASK = 4'd6
    } mmioClass_t;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } mmioSettle_t;

    // Settle runs for counts 0..SETTLE_LAST, long enough to flush the synchroniser.
    localparam logic [1:0] SETTLE_LAST = 2'd2;

endpackage

// File: rtl/mmio_in_sync.sv
// One input port: 3-flop synchroniser plus edge-change detect.
// data is the second stage; change compares stages 2 and 3 and is forced low until en.
module mmio_in_sync
    import mmio_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] change
);

    logic [WIDTH-1:0] s1, s2, s3;

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign data   = s2;
    assign change = en ? (s2 ^ s3) : '0;

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of NUM_PORTS input/output ports on one 256-byte page.
// Define MMIO_IRQ_EN to add per-port MASK registers (class 6) and a registered irq.
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          NUM_PORTS = 4,
    parameter logic [15:0] BASE_ADDR = 16'h2000
) (
    input  logic                       clock,
    input  logic                       reset_L,
    input  logic [15:0]                memAddr,
    input  logic [15:0]                dataIn,
    input  logic                       re_L,
    input  logic                       we_L,
    input  logic [NUM_PORTS*WIDTH-1:0] portIn,
    output logic [NUM_PORTS*WIDTH-1:0] portOut,
    output logic [15:0]                rdData,
    output logic                       drive_L,
    output logic                       irq
);

    logic [NUM_PORTS-1:0][WIDTH-1:0] out_q, chg_q, sync_data, sync_chg;
    logic [NUM_PORTS-1:0]            sel;
    logic [WIDTH-1:0]                wdata, rd_word;
    logic [3:0]                      idx;
    logic                            page_hit, cls_ok, rd_hit, run;
    mmioClass_t                      cls;
    mmioSettle_t                     state_q, state_d;
    logic [1:0]                      cnt_q, cnt_d;

    assign wdata = dataIn[WIDTH-1:0];

    always_comb begin
        cls      = mmioClass_t'(memAddr[7:4]);
        idx      = memAddr[3:0];
        page_hit = memAddr[15:MMIO_PAGE_BITS] == BASE_ADDR[15:MMIO_PAGE_BITS];
        case (cls)
            CLS_DATA, CLS_SET, CLS_CLR, CLS_TGL, CLS_CHG, CLS_ORB: cls_ok = 1'b1;
`ifdef MMIO_IRQ_EN
            CLS_MASK: cls_ok = 1'b1;
`endif
            default: cls_ok = 1'b0;
        endcase
        // An index beyond NUM_PORTS selects nothing, which makes it a miss.
        sel = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            sel[i] = page_hit && cls_ok && (idx == 4'(i));
        rd_hit = !re_L && (|sel);
    end

`ifdef MMIO_IRQ_EN
    logic [NUM_PORTS-1:0][WIDTH-1:0] mask_q;
    logic                            irq_q;
`endif

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel[i]) begin
                case (cls)
                    CLS_DATA: rd_word = sync_data[i];
                    CLS_CHG:  rd_word = chg_q[i];
                    CLS_ORB:  rd_word = out_q[i];
`ifdef MMIO_IRQ_EN
                    CLS_MASK: rd_word = mask_q[i];
`endif
                    default:  rd_word = '0;
                endcase
            end
        end
        rdData  = rd_hit ? 16'(rd_word) : 16'h0000;
        drive_L = !rd_hit;
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q <= ST_SETTLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_SETTLE;
                cnt_d   = 2'd0;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_SETTLE;
        endcase
    end

    assign run = state_q == ST_RUN;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        mmio_in_sync #(.WIDTH(WIDTH)) u_sync (
            .clock  (clock),
            .reset_L(reset_L),
            .en     (run),
            .din    (portIn[g*WIDTH +: WIDTH]),
            .data   (sync_data[g]),
            .change (sync_chg[g])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            out_q <= '0;
            chg_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                // Read-to-clear keeps any change arriving in the clearing cycle.
                if (!re_L && sel[i] && cls == CLS_CHG)
                    chg_q[i] <= sync_chg[i];
                else
                    chg_q[i] <= chg_q[i] | sync_chg[i];
                if (!we_L && sel[i]) begin
                    case (cls)
                        CLS_DATA: out_q[i] <= wdata;
                        CLS_SET:  out_q[i] <= out_q[i] | wdata;
                        CLS_CLR:  out_q[i] <= out_q[i] & ~wdata;
                        CLS_TGL:  out_q[i] <= out_q[i] ^ wdata;
                        default:  out_q[i] <= out_q[i];
                    endcase
                end
            end
        end
    end

    assign portOut = out_q;

`ifdef MMIO_IRQ_EN
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            irq_q <= |(chg_q & mask_q);
            for (int i = 0; i < NUM_PORTS; i++)
                if (!we_L && sel[i] && cls == CLS_MASK)
                    mask_q[i] <= wdata;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_port_bank.sv
// Randomised and directed bench for mmio_port_bank against a cycle-level
// behavioural model of the register page (works with or without MMIO_IRQ_EN).
module tb_mmio_port_bank;

    localparam int W  = 16;
    localparam int NP = 4;
`ifdef MMIO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_L;
    logic [15:0]       memAddr, dataIn;
    logic              re_L, we_L;
    logic [NP*W-1:0]   portIn;
    logic [NP*W-1:0]   portOut;
    logic [15:0]       rdData;
    logic              drive_L, irq;

    always #5 clock = ~clock;

    mmio_port_bank #(.WIDTH(W), .NUM_PORTS(NP), .BASE_ADDR(16'h2000)) dut (
        .clock  (clock),
        .reset_L(reset_L),
        .memAddr(memAddr),
        .dataIn (dataIn),
        .re_L   (re_L),
        .we_L   (we_L),
        .portIn (portIn),
        .portOut(portOut),
        .rdData (rdData),
        .drive_L(drive_L),
        .irq    (irq)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: register contents plus the last three samples of each input port
    // (index 0 newest); rel counts edges since reset was released.
    logic [15:0] m_out[NP], m_chg[NP], m_mask[NP];
    logic [15:0] hist[NP][3];
    logic        m_irq;
    int          rel;

    function automatic bit m_hit(input logic [15:0] a);
        int c, p;
        c = int'(a[7:4]);
        p = int'(a[3:0]);
        return a[15:8] == 8'h20 && p < NP && (c <= 5 || (IRQ && c == 6));
    endfunction

    function automatic logic [15:0] m_rd(input logic [15:0] a, input logic re);
        int c, p;
        c = int'(a[7:4]);
        p = int'(a[3:0]);
        if (re || !m_hit(a)) return 16'h0000;
        case (c)
            0:       return hist[p][1];
            4:       return m_chg[p];
            5:       return m_out[p];
            6:       return m_mask[p];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_edge();
        logic [15:0] cv[NP];
        logic        irq_n;
        int          c, p;
        bit          h;
        c = int'(memAddr[7:4]);
        p = int'(memAddr[3:0]);
        h = m_hit(memAddr);
        if (!reset_L) begin
            for (int i = 0; i < NP; i++) begin
                m_out[i] = 0; m_chg[i] = 0; m_mask[i] = 0;
                hist[i][0] = 0; hist[i][1] = 0; hist[i][2] = 0;
            end
            m_irq = 1'b0;
            rel = 0;
            return;
        end
        irq_n = 1'b0;
        for (int i = 0; i < NP; i++) begin
            cv[i] = (rel >= 3) ? (hist[i][1] ^ hist[i][2]) : 16'h0000;
            if (IRQ && (m_chg[i] & m_mask[i]) != 16'h0000) irq_n = 1'b1;
        end
        for (int i = 0; i < NP; i++) begin
            if (!re_L && h && c == 4 && p == i) m_chg[i] = cv[i];
            else m_chg[i] = m_chg[i] | cv[i];
        end
        if (!we_L && h) begin
            case (c)
                0: m_out[p] = dataIn;
                1: m_out[p] = m_out[p] | dataIn;
                2: m_out[p] = m_out[p] & ~dataIn;
                3: m_out[p] = m_out[p] ^ dataIn;
                6: m_mask[p] = dataIn;
                default: ;
            endcase
        end
        for (int i = 0; i < NP; i++) begin
            hist[i][2] = hist[i][1];
            hist[i][1] = hist[i][0];
            hist[i][0] = portIn[i*W +: W];
        end
        m_irq = irq_n;
        if (rel < 3) rel++;
    endtask

    logic [15:0] last_rd;
    logic        last_drv;

    // One bus cycle, entered and left on a falling edge.
    task automatic cyc(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d);
        re_L = re; we_L = we; memAddr = a; dataIn = d;
        #1;
        last_rd  = rdData;
        last_drv = drive_L;
        chk("rdData", rdData, m_rd(a, re));
        chk("drive_L", drive_L, (!re && m_hit(a)) ? 64'd0 : 64'd1);
        m_edge();
        @(posedge clock);
        #1;
        for (int i = 0; i < NP; i++)
            chk($sformatf("portOut%0d", i), portOut[i*W +: W], m_out[i]);
        chk("irq", irq, m_irq);
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b1, 16'h0000, 16'h0000);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(1'b0, 1'b1, a, 16'h0000);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    initial begin
        logic [15:0] a;
        int          p;
        reset_L = 1'b0; re_L = 1'b1; we_L = 1'b1;
        memAddr = 16'h0; dataIn = 16'h0; portIn = '0;
        for (int i = 0; i < NP; i++) begin
            m_out[i] = 0; m_chg[i] = 0; m_mask[i] = 0;
            hist[i][0] = 0; hist[i][1] = 0; hist[i][2] = 0;
        end
        m_irq = 1'b0;
        rel = 0;
        @(negedge clock);

        // Input high through reset must not register as a change.
        portIn[15:0] = 16'hFFFF;
        repeat (2) idle();
        chk("reset_portOut", portOut, 64'd0);
        chk("reset_irq", irq, 64'd0);
        reset_L = 1'b1;
        repeat (6) idle();
        rd(16'h2040);
        chk("chg0_after_reset", last_rd, 64'h0000);
        rd(16'h2000);
        chk("data0", last_rd, 64'hFFFF);
        chk("data0_drive", last_drv, 64'd0);

        // Atomic write classes on port 1.
        wr(16'h2001, 16'h00F0); rd(16'h2051); chk("orb1_data", last_rd, 64'h00F0);
        wr(16'h2011, 16'h0F00); rd(16'h2051); chk("orb1_set",  last_rd, 64'h0FF0);
        wr(16'h2021, 16'h0030); rd(16'h2051); chk("orb1_clr",  last_rd, 64'h0FC0);
        wr(16'h2031, 16'h8000); rd(16'h2051); chk("orb1_tgl",  last_rd, 64'h8FC0);
        rd(16'h2011);
        chk("set_read_zero", last_rd, 64'h0000);
        chk("set_read_hit", last_drv, 64'd0);

        // Synchroniser latency and read-to-clear.
        portIn[2*W +: W] = 16'h0005;
        idle();
        rd(16'h2002);
        chk("data2_one_edge", last_rd, 64'h0000);
        rd(16'h2002);
        chk("data2_two_edges", last_rd, 64'h0005);
        rd(16'h2042); chk("chg2_first", last_rd, 64'h0005);
        rd(16'h2042); chk("chg2_cleared", last_rd, 64'h0000);

        // A change landing on the clearing edge survives the clear.
        portIn[2*W] = ~portIn[2*W];
        idle(); idle();
        rd(16'h2042); chk("chg2_old", last_rd, 64'h0000);
        rd(16'h2042); chk("chg2_survivor", last_rd, 64'h0001);

        // Misses: bad index, unmapped class, other page.
        cyc(1'b0, 1'b0, 16'h2004, 16'hFFFF);
        chk("miss_idx_drive", last_drv, 64'd1);
        chk("miss_idx_data", last_rd, 64'h0000);
        cyc(1'b0, 1'b0, 16'h2070, 16'hFFFF);
        chk("miss_cls_drive", last_drv, 64'd1);
        cyc(1'b0, 1'b0, 16'h2100, 16'hFFFF);
        chk("miss_page_drive", last_drv, 64'd1);
        chk("miss_page_data", last_rd, 64'h0000);
        chk("miss_portOut1", portOut[W +: W], 64'h8FC0);

        // Interrupt path: mask port 3 bit 0, raise it, then clear by reading CHG3.
        wr(16'h2063, 16'h0001);
        portIn[3*W] = 1'b1;
        repeat (3) idle();
        chk("irq_before", irq, 64'd0);
        idle();
        chk("irq_raised", irq, IRQ ? 64'd1 : 64'd0);
        rd(16'h2043);
        idle();
        chk("irq_cleared", irq, 64'd0);

        // Random traffic, including occasional mid-stream resets.
        repeat (500) begin
            reset_L = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, NP - 1);
                portIn[p*W +: W] = portIn[p*W +: W] ^ (16'(1) << $urandom_range(0, 15));
            end
            if ($urandom_range(0, 9) == 0) begin
                a = 16'($urandom);
            end else begin
                a = 16'h2000;
                a[7:4] = 4'($urandom_range(0, 7));
                a[3:0] = 4'($urandom_range(0, 5));
            end
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
                a, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
